// File: rtl/unsag_serial.sv
// -----------------------------------------------------------------------------
// unsag_serial
//
// Bit-serial inverse Sheep-And-Goats stage. It takes a word produced by the
// combinational `sag` unit plus the control word that was used to produce it,
// and rebuilds the original data word, one bit per clock.
//
// The forward `sag` packs the data bits whose control bit is 1 at the low end
// of the result, in ascending order. It packs the data bits whose control bit
// is 0 at the high end, in reverse order: the lowest such bit lands in the MSB.
// This block walks the original bit positions i = 0..WIDTH-1 and fetches each
// bit back. Ones are taken from a pointer j that climbs from the bottom of the
// shuffled word. Zeros are taken from a pointer k that descends from the top.
//
// Handshake: a word moves across an interface only on a rising clock edge where
// that interface's valid and ready are both high. A producer holding valid
// keeps its payload stable until the transfer. out_valid never drops without
// out_ready. in_ready is high only in IDLE and is forced low while resetn is low.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   in_valid   in_data/in_ctrl are valid
//   in_ready   block can accept a word (IDLE only)
//   in_data    SAG-shuffled word
//   in_ctrl    SAG control word originally applied
//   out_valid  out_data holds a finished result
//   out_ready  consumer accepts out_data
//   out_data   reconstructed original word (held until the next result)
//   busy       high in RUN or DONE
//   stateDbg   current FSM state (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------
module unsag_serial #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic [1:0]       stateDbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    stateT            state;
    stateT            stateNext;
    logic [WIDTH-1:0] dReg;
    logic [WIDTH-1:0] cReg;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] workNext;
    logic [WIDTH-1:0] outDataReg;
    logic             outValidReg;
    logic [CW-1:0]    iIdx;
    logic [CW-1:0]    jIdx;
    logic [CW-1:0]    kIdx;
    logic             bitSel;
    logic             lastBit;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (in_valid) stateNext = RUN;
            RUN:  if (lastBit) stateNext = DONE;
            DONE: if (out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Bit fetch for the current position. On the last position j == k, so the
    // MSB control bit selects between two equal pointers and has no effect.
    always_comb begin
        bitSel   = cReg[iIdx] ? dReg[jIdx] : dReg[kIdx];
        lastBit  = (iIdx == LAST_IDX);
        workNext = work;
        workNext[iIdx] = bitSel;
    end

    // Datapath. The pointers are frozen on the last position so they never
    // wrap (an all-zero control word would otherwise take k below zero).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dReg        <= '0;
            cReg        <= '0;
            work        <= '0;
            outDataReg  <= '0;
            outValidReg <= 1'b0;
            iIdx        <= '0;
            jIdx        <= '0;
            kIdx        <= LAST_IDX;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dReg <= in_data;
                        cReg <= in_ctrl;
                        work <= '0;
                        iIdx <= '0;
                        jIdx <= '0;
                        kIdx <= LAST_IDX;
                    end
                end
                RUN: begin
                    work <= workNext;
                    if (lastBit) begin
                        outDataReg  <= workNext;
                        outValidReg <= 1'b1;
                    end else begin
                        iIdx <= iIdx + CW'(1);
                        if (cReg[iIdx]) begin
                            jIdx <= jIdx + CW'(1);
                        end else begin
                            kIdx <= kIdx - CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValidReg <= 1'b0;
                    end
                end
                default: begin
                    outValidReg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = resetn && (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = outValidReg;
    assign out_data  = outDataReg;
    assign stateDbg  = state;

endmodule

// File: tb/tb_unsag_serial.sv
// -----------------------------------------------------------------------------
// tb_unsag_serial
//
// Directed vector table for the inverse SAG stage, hand sequences for
// backpressure and reset during RUN, and a round-trip sweep that feeds words
// made by a forward sag model and expects the original words back.
// -----------------------------------------------------------------------------
module tb_unsag_serial;

    localparam int W = 8;

    logic         clk;
    logic         resetn;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [W-1:0] in_ctrl;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;
    logic [1:0]   stateDbg;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    unsag_serial #(.WIDTH(W)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy),
        .stateDbg (stateDbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // On the last RUN position both pointers must meet.
    always @(negedge clk) begin
        if (resetn && stateDbg == 2'd1 && dut.iIdx == 3'd7) begin
            checks++;
            if (dut.jIdx !== dut.kIdx) begin
                errors++;
                $display("FAIL jk_invariant: j=%0d k=%0d", dut.jIdx, dut.kIdx);
            end
        end
    end

    // Forward sag model.
    function automatic logic [W-1:0] sagFn(input logic [W-1:0] d, input logic [W-1:0] c);
        logic [W-1:0] r;
        int j;
        int k;
        r = '0;
        j = 0;
        k = W - 1;
        for (int i = 0; i < W; i++) begin
            if (c[i]) begin
                r[j] = d[i];
                j++;
            end else begin
                r[k] = d[i];
                k--;
            end
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // Present a word and return at the negedge after the accepting edge.
    task automatic acceptWord(input logic [W-1:0] d, input logic [W-1:0] c);
        int waitCnt;
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
        waitCnt  = 0;
        while (!in_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) check("accept_timeout", 32'(waitCnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count cycles from acceptance to out_valid; also check busy over the span.
    task automatic waitOut(input string name, output int lat);
        int busyLow;
        lat     = 0;
        busyLow = 0;
        while (!out_valid && lat < 40) begin
            if (!busy) busyLow++;
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'd8);
        check({name, "_busy_span"}, 32'(busyLow), 32'd0);
    endtask

    // Stall the consumer, then complete the output handshake.
    task automatic releaseOut(input int stall);
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string        name;
        logic [W-1:0] data;
        logic [W-1:0] ctrl;
        logic [W-1:0] expOut;
    } vecT;

    vecT vecs[9];

    initial begin
        int lat;
        int sawValid;
        logic [W-1:0] di;
        logic [W-1:0] ci;
        logic [W-1:0] expV;

        vecs[0] = '{"known_55_0f",   8'h55, 8'h0F, 8'hA5};
        vecs[1] = '{"identity_3c",   8'h3C, 8'hFF, 8'h3C};
        vecs[2] = '{"reverse_01",    8'h01, 8'h00, 8'h80};
        vecs[3] = '{"reverse_f0",    8'hF0, 8'h00, 8'h0F};
        vecs[4] = '{"ctrl_f0",       8'h5A, 8'hF0, 8'hAA};
        vecs[5] = '{"ctrl_aa",       8'h0F, 8'hAA, 8'hAA};
        vecs[6] = '{"ctrl_01",       8'h81, 8'h01, 8'h03};
        vecs[7] = '{"msb_ignored_7f", 8'h3C, 8'h7F, 8'h3C};
        vecs[8] = '{"msb_ignored_80", 8'h01, 8'h80, 8'h80};

        // ---------------- reset ----------------
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        #2;
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_state",     32'(stateDbg),  32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // ---------------- table-driven vectors ----------------
        for (int v = 0; v < 9; v++) begin
            acceptWord(vecs[v].data, vecs[v].ctrl);
            waitOut(vecs[v].name, lat);
            check({vecs[v].name, "_out"}, 32'(out_data), 32'(vecs[v].expOut));
            releaseOut(v % 3);
            check({vecs[v].name, "_valid_drop"}, 32'(out_valid), 32'd0);
        end

        // ---------------- backpressure ----------------
        acceptWord(8'h55, 8'h0F);
        waitOut("bp_first", lat);
        check("bp_first_out", 32'(out_data), 32'hA5);
        in_valid  = 1'b1;
        in_data   = 8'h01;
        in_ctrl   = 8'h00;
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("bp_hold_data",  32'(out_data),  32'hA5);
            check("bp_hold_ready", 32'(in_ready),  32'd0);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_after_hs_valid", 32'(out_valid), 32'd0);
        check("bp_after_hs_ready", 32'(in_ready),  32'd1);
        check("bp_after_hs_busy",  32'(busy),      32'd0);
        check("bp_after_hs_data",  32'(out_data),  32'hA5);
        @(negedge clk);
        check("bp_second_taken", 32'(busy), 32'd1);
        in_valid = 1'b0;
        waitOut("bp_second", lat);
        check("bp_second_out", 32'(out_data), 32'h80);
        releaseOut(0);

        // ---------------- reset during RUN ----------------
        acceptWord(8'h55, 8'h0F);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data",  32'(out_data),  32'd0);
        check("mid_rst_busy",      32'(busy),      32'd0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd0);
        sawValid = 0;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            if (out_valid) sawValid++;
        end
        resetn = 1'b1;
        #1;
        check("mid_rst_release_ready", 32'(in_ready), 32'd1);
        for (int s = 0; s < 12; s++) begin
            @(negedge clk);
            if (out_valid) sawValid++;
        end
        check("mid_rst_no_output", 32'(sawValid), 32'd0);
        acceptWord(8'h3C, 8'hFF);
        waitOut("mid_rst_next", lat);
        check("mid_rst_next_out", 32'(out_data), 32'h3C);
        releaseOut(1);

        // ---------------- round trip with scoreboard ----------------
        for (int n = 0; n < 756; n++) begin
            if (n < 256) begin
                ci = 8'(n);
                di = 8'($urandom_range(0, 255));
            end else begin
                ci = 8'($urandom_range(0, 255));
                di = 8'($urandom_range(0, 255));
            end
            exp_q.push_back(di);
            acceptWord(sagFn(di, ci), ci);
            waitOut("rt", lat);
            expV = exp_q.pop_front();
            check("rt_out", 32'(out_data), 32'(expV));
            releaseOut($urandom_range(0, 3));
        end
        check("rt_queue_empty", 32'(exp_q.size()), 32'd0);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
